// File: rtl/cpu_wide_alu.sv
// cpu_wide_alu
// Multi-cycle, width-selectable 6502 ALU. Operands of 8..DATA_W bits are
// processed one SLICE_W-bit slice per clock, low slice first, with the carry
// chained between slices. The result and N/V/Z/C flags are registered on the
// final cycle and held until the next operation completes.
//
// Optional build macro: CPU_WIDE_ALU_BCD_EN enables packed-BCD ADC/SBC when
// the latched D flag is set. Without it, i_d is ignored.
//
// Ports:
//   i_clk, i_rst          clock (rising edge), async active-high reset
//   i_start               request, sampled only while idle
//   i_op[3:0]             0 ADC 1 SBC 2 AND 3 ORA 4 EOR 5 ASL 6 LSR 7 ROL
//                         8 ROR 9 INC 10 DEC 11 CMP 12 BIT 13-15 PASS
//   i_width[2:0]          width code 0=8,1=16,2=32,3=64,4..7=128
//   i_a, i_b              operands (i_a is the accumulator/target)
//   i_c_in, i_v_in, i_d   current C, V, D status bits
//   o_busy, o_done        operation in progress / one-cycle completion pulse
//   o_result              result, zero-extended above the effective width
//   o_n, o_v, o_z, o_c    resulting flags
module cpu_wide_alu #(
  parameter int DATA_W  = 128,
  parameter int SLICE_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [3:0]        i_op,
  input  logic [2:0]        i_width,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic              i_c_in,
  input  logic              i_v_in,
  input  logic              i_d,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] o_result,
  output logic              o_n,
  output logic              o_v,
  output logic              o_z,
  output logic              o_c
);
  localparam int NS_MAX = DATA_W / SLICE_W;
  localparam int KW     = (NS_MAX > 1) ? $clog2(NS_MAX) : 1;
  localparam int IW     = $clog2(DATA_W);
  localparam int WW     = IW + 1;

  localparam logic [3:0] OP_ADC = 4'd0,  OP_SBC = 4'd1,  OP_AND = 4'd2;
  localparam logic [3:0] OP_ORA = 4'd3,  OP_EOR = 4'd4,  OP_ASL = 4'd5;
  localparam logic [3:0] OP_LSR = 4'd6,  OP_ROL = 4'd7,  OP_ROR = 4'd8;
  localparam logic [3:0] OP_INC = 4'd9,  OP_DEC = 4'd10, OP_CMP = 4'd11;
  localparam logic [3:0] OP_BIT = 4'd12;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t            state_q, state_d;
  logic [3:0]        op_q;
  logic [DATA_W-1:0] a_q, b_q, wrk_q, wrk_d;
  logic              c_q, v_q;
  logic [WW-1:0]     w_q;
  logic [KW-1:0]     k_q, last_q;
  logic              carry_q, bcarry_q, vbin_q;
  logic              c_run, bc_run, v_run;

  int                pos;
  logic [IW-1:0]     idx, idx_lo, idx_hi, msb, nxt;
  logic              a_bit, b_bit, op_b, lo_bit, hi_bit, top, sum_bit, cout;
  logic [DATA_W-1:0] mask, fin_result;
  logic              fin_n, fin_v, fin_z, fin_c;

  // Width code 4..7 all mean 128 bits, further capped at DATA_W.
  function automatic logic [WW-1:0] eff_width(input logic [2:0] code);
    int w;
    w = 8 << ((code > 3'd4) ? 3'd4 : code);
    if (w > DATA_W) w = DATA_W;
    return WW'(w);
  endfunction

  function automatic logic [KW-1:0] last_slice(input logic [WW-1:0] w);
    return (int'(w) >= SLICE_W) ? KW'(int'(w) / SLICE_W - 1) : '0;
  endfunction

  // INC is A+0+1, DEC is A+~0+0, CMP is A+~B+1; ADC/SBC take the C flag.
  function automatic logic carry_seed(input logic [3:0] op, input logic c);
    case (op)
      OP_CMP, OP_INC: return 1'b1;
      OP_DEC:         return 1'b0;
      default:        return c;
    endcase
  endfunction

`ifdef CPU_WIDE_ALU_BCD_EN
  logic       d_q;
  logic [3:0] dig_a, dig_b;
  logic [4:0] dsum;
`else
  logic unused_d;
  assign unused_d = i_d;
`endif

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (i_start) state_d = S_RUN;
      S_RUN:   if (k_q == last_q) state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    o_busy = (state_q != S_IDLE);
  end

  // One slice of work: a binary ripple chain gives sums, carry and signed
  // overflow at bit W-1; bits at or above W are never written so the work
  // register stays zero-extended.
  always_comb begin
    wrk_d   = wrk_q;
    bc_run  = bcarry_q;
    v_run   = vbin_q;
    pos     = 0;
    idx     = '0;
    idx_lo  = '0;
    idx_hi  = '0;
    a_bit   = 1'b0;
    b_bit   = 1'b0;
    op_b    = 1'b0;
    lo_bit  = 1'b0;
    hi_bit  = 1'b0;
    top     = 1'b0;
    sum_bit = 1'b0;
    cout    = 1'b0;
    for (int j = 0; j < SLICE_W; j++) begin
      pos = int'(k_q) * SLICE_W + j;
      if (pos < int'(w_q)) begin
        idx    = IW'(pos);
        idx_lo = IW'(pos - 1);
        idx_hi = IW'(pos + 1);
        top    = (pos == int'(w_q) - 1);
        a_bit  = a_q[idx];
        b_bit  = b_q[idx];
        lo_bit = (pos == 0) ? 1'b0 : a_q[idx_lo];
        hi_bit = top ? 1'b0 : a_q[idx_hi];
        case (op_q)
          OP_ADC:         op_b = b_bit;
          OP_SBC, OP_CMP: op_b = ~b_bit;
          OP_DEC:         op_b = 1'b1;
          default:        op_b = 1'b0;
        endcase
        sum_bit = a_bit ^ op_b ^ bc_run;
        cout    = (a_bit & op_b) | (bc_run & (a_bit ^ op_b));
        if (top) v_run = bc_run ^ cout;
        bc_run = cout;
        case (op_q)
          OP_ADC, OP_SBC, OP_INC, OP_DEC, OP_CMP: wrk_d[idx] = sum_bit;
          OP_AND, OP_BIT: wrk_d[idx] = a_bit & b_bit;
          OP_ORA:         wrk_d[idx] = a_bit | b_bit;
          OP_EOR:         wrk_d[idx] = a_bit ^ b_bit;
          OP_ASL:         wrk_d[idx] = lo_bit;
          OP_ROL:         wrk_d[idx] = (pos == 0) ? c_q : lo_bit;
          OP_LSR:         wrk_d[idx] = hi_bit;
          OP_ROR:         wrk_d[idx] = top ? c_q : hi_bit;
          default:        wrk_d[idx] = a_bit;
        endcase
      end
    end
    c_run = bc_run;
`ifdef CPU_WIDE_ALU_BCD_EN
    // Decimal mode overwrites the binary sum digit by digit and chains the
    // decimal carry; the binary chain above still supplies V.
    dig_a = '0;
    dig_b = '0;
    dsum  = '0;
    if (d_q && (op_q == OP_ADC || op_q == OP_SBC)) begin
      c_run = carry_q;
      for (int g = 0; g < SLICE_W / 4; g++) begin
        pos = int'(k_q) * SLICE_W + 4 * g;
        if (pos < int'(w_q)) begin
          idx   = IW'(pos);
          dig_a = a_q[idx +: 4];
          dig_b = (op_q == OP_SBC) ? ~b_q[idx +: 4] : b_q[idx +: 4];
          dsum  = {1'b0, dig_a} + {1'b0, dig_b} + {4'd0, c_run};
          if (op_q == OP_ADC) begin
            c_run = (dsum > 5'd9);
            if (c_run) dsum = dsum + 5'd6;
          end else begin
            c_run = dsum[4];
            if (!c_run) dsum = dsum - 5'd6;
          end
          wrk_d[idx +: 4] = dsum[3:0];
        end
      end
    end
`endif
  end

  // Final result and flags. CMP/BIT/PASS return A while the work register
  // holds A-B (CMP) or A&B (BIT) for the N/Z flags.
  always_comb begin
    msb  = IW'(int'(w_q) - 1);
    nxt  = IW'(int'(w_q) - 2);
    mask = '0;
    for (int j = 0; j < DATA_W; j++)
      if (j < int'(w_q)) mask[j] = 1'b1;
    fin_result = (op_q == OP_CMP || op_q == OP_BIT || op_q >= 4'd13) ? (a_q & mask) : wrk_q;
    fin_n = (op_q == OP_BIT) ? b_q[msb] : wrk_q[msb];
    fin_z = (wrk_q == '0);
    case (op_q)
      OP_ADC, OP_SBC, OP_CMP: fin_c = carry_q;
      OP_ASL, OP_ROL:         fin_c = a_q[msb];
      OP_LSR, OP_ROR:         fin_c = a_q[0];
      default:                fin_c = c_q;
    endcase
    case (op_q)
      OP_ADC, OP_SBC: fin_v = vbin_q;
      OP_BIT:         fin_v = b_q[nxt];
      default:        fin_v = v_q;
    endcase
  end

  // Operand latch, slice accumulation and registered outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
      w_q      <= '0;
      k_q      <= '0;
      last_q   <= '0;
      wrk_q    <= '0;
      carry_q  <= 1'b0;
      bcarry_q <= 1'b0;
      vbin_q   <= 1'b0;
      o_done   <= 1'b0;
      o_result <= '0;
      o_n      <= 1'b0;
      o_v      <= 1'b0;
      o_z      <= 1'b0;
      o_c      <= 1'b0;
`ifdef CPU_WIDE_ALU_BCD_EN
      d_q      <= 1'b0;
`endif
    end else begin
      o_done <= (state_q == S_FIN);
      case (state_q)
        S_IDLE: if (i_start) begin
          op_q     <= i_op;
          a_q      <= i_a;
          b_q      <= i_b;
          c_q      <= i_c_in;
          v_q      <= i_v_in;
          w_q      <= eff_width(i_width);
          last_q   <= last_slice(eff_width(i_width));
          k_q      <= '0;
          wrk_q    <= '0;
          carry_q  <= carry_seed(i_op, i_c_in);
          bcarry_q <= carry_seed(i_op, i_c_in);
          vbin_q   <= 1'b0;
`ifdef CPU_WIDE_ALU_BCD_EN
          d_q      <= i_d;
`endif
        end
        S_RUN: begin
          wrk_q    <= wrk_d;
          carry_q  <= c_run;
          bcarry_q <= bc_run;
          vbin_q   <= v_run;
          k_q      <= k_q + 1'b1;
        end
        S_FIN: begin
          o_result <= fin_result;
          o_n      <= fin_n;
          o_v      <= fin_v;
          o_z      <= fin_z;
          o_c      <= fin_c;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_wide_alu.sv
// tb_cpu_wide_alu
// Scoreboard bench for cpu_wide_alu: the driver computes each expected
// response with an arithmetic reference model and queues it; a monitor pops
// and compares whenever o_done pulses, including the completion cycle.
module tb_cpu_wide_alu;
  localparam int DATA_W  = 128;
  localparam int SLICE_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [3:0]        op;
  logic [2:0]        width;
  logic [DATA_W-1:0] a, b;
  logic              c_in, v_in, d_in;
  logic              busy, done;
  logic [DATA_W-1:0] result;
  logic              n_f, v_f, z_f, c_f;

  always #5 clk = ~clk;

  cpu_wide_alu #(.DATA_W(DATA_W), .SLICE_W(SLICE_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_op(op), .i_width(width),
    .i_a(a), .i_b(b), .i_c_in(c_in), .i_v_in(v_in), .i_d(d_in),
    .o_busy(busy), .o_done(done), .o_result(result),
    .o_n(n_f), .o_v(v_f), .o_z(z_f), .o_c(c_f)
  );

  typedef struct {
    logic [DATA_W-1:0] res;
    logic n, v, z, c;
    int due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   done_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int eff_w(input logic [2:0] wc);
    int w;
    w = 8 << ((wc > 3'd4) ? 3'd4 : wc);
    return (w > DATA_W) ? DATA_W : w;
  endfunction

  function automatic logic [DATA_W:0] pow10(input int nd);
    logic [DATA_W:0] r;
    r = 1;
    for (int i = 0; i < nd; i++) r = r * 129'd10;
    return r;
  endfunction

  function automatic logic [DATA_W:0] bcd2int(input logic [DATA_W:0] x, input int nd);
    logic [DATA_W:0] r;
    r = 0;
    for (int i = nd - 1; i >= 0; i--) r = r * 129'd10 + ((x >> (4 * i)) & 129'hF);
    return r;
  endfunction

  function automatic logic [DATA_W:0] int2bcd(input logic [DATA_W:0] x, input int nd);
    logic [DATA_W:0] r, t;
    r = 0;
    t = x;
    for (int i = 0; i < nd; i++) begin
      r = r | ((t % 129'd10) << (4 * i));
      t = t / 129'd10;
    end
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] rand_wide();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [DATA_W-1:0] rand_bcd();
    logic [DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < DATA_W / 4; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  // Reference model: whole-word arithmetic on a 129-bit value, masked to W.
  function automatic exp_t model(input logic [3:0] o, input logic [2:0] wc,
                                 input logic [DATA_W-1:0] ai, input logic [DATA_W-1:0] bi,
                                 input logic c, input logic v, input logic d);
    exp_t e;
    int w;
    logic [DATA_W:0] mask, x, y, r, fv, lim, da, db, s;
    w    = eff_w(wc);
    mask = (129'd1 << w) - 129'd1;
    x    = {1'b0, ai} & mask;
    y    = {1'b0, bi} & mask;
    e.c  = c;
    e.v  = v;
    r    = x;
    case (o)
      4'd0: begin
        s = x + y + 129'(c);
        r = s & mask;
        e.c = s[w];
        e.v = (x[w-1] == y[w-1]) && (r[w-1] != x[w-1]);
      end
      4'd1: begin
        r = (x - y - 129'(!c)) & mask;
        e.c = (x + 129'(c)) >= (y + 129'd1);
        e.v = (x[w-1] != y[w-1]) && (r[w-1] != x[w-1]);
      end
      4'd2, 4'd12: r = x & y;
      4'd3:  r = x | y;
      4'd4:  r = x ^ y;
      4'd5:  begin r = (x << 1) & mask; e.c = x[w-1]; end
      4'd6:  begin r = x >> 1; e.c = x[0]; end
      4'd7:  begin r = ((x << 1) | 129'(c)) & mask; e.c = x[w-1]; end
      4'd8:  begin r = (x >> 1) | (129'(c) << (w - 1)); e.c = x[0]; end
      4'd9:  r = (x + 129'd1) & mask;
      4'd10: r = (x - 129'd1) & mask;
      4'd11: begin r = (x - y) & mask; e.c = (x >= y); end
      default: r = x;
    endcase
`ifdef CPU_WIDE_ALU_BCD_EN
    if (d && o <= 4'd1) begin
      lim = pow10(w / 4);
      da  = bcd2int(x, w / 4);
      db  = bcd2int(y, w / 4);
      if (o == 4'd0) begin
        s = da + db + 129'(c);
        e.c = (s >= lim);
        if (e.c) s = s - lim;
      end else begin
        e.c = (da + 129'(c)) >= (db + 129'd1);
        s = e.c ? (da + 129'(c) - db - 129'd1) : (da + 129'(c) + lim - db - 129'd1);
      end
      r = int2bcd(s, w / 4);
    end
`else
    lim = 0; da = d ? 129'd0 : 129'd0; db = 0;
`endif
    fv  = r;
    e.res = r[DATA_W-1:0];
    if (o == 4'd11 || o >= 4'd12) e.res = x[DATA_W-1:0];
    e.n = fv[w-1];
    if (o == 4'd12) begin
      e.n = y[w-1];
      e.v = y[w-2];
    end
    e.z = (fv == 0);
    e.due = 0;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [DATA_W-1:0] act,
                             input logic [DATA_W-1:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Issue one operation at a negedge; returns just after the accepting edge.
  task automatic applyStimulus(input logic [3:0] o, input logic [2:0] wc,
                               input logic [DATA_W-1:0] ai, input logic [DATA_W-1:0] bi,
                               input logic c, input logic v, input logic d);
    exp_t e;
    int w;
    e = model(o, wc, ai, bi, c, v, d);
    w = eff_w(wc);
    e.due = cyc + ((w < SLICE_W) ? 1 : w / SLICE_W) + 2;
    op = o; width = wc; a = ai; b = bi; c_in = c; v_in = v; d_in = d;
    start = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    op = 4'($urandom); width = 3'($urandom); a = rand_wide(); b = rand_wide();
    c_in = 1'($urandom); v_in = 1'($urandom); d_in = 1'($urandom);
  endtask

  task automatic waitDone(input string name);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done && k < 200);
    if (!done) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL %s_timeout: got no o_done in %0d cycles, expected a pulse", name, k);
    end
  endtask

  // Monitor: compare every completion against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && done) begin
      done_seen++;
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_done: got o_done=1, expected no pending op");
      end else begin
        mon_e = sb.pop_front();
        checkOutput("result", result, mon_e.res);
        checkOutput("flag_n", DATA_W'(n_f), DATA_W'(mon_e.n));
        checkOutput("flag_v", DATA_W'(v_f), DATA_W'(mon_e.v));
        checkOutput("flag_z", DATA_W'(z_f), DATA_W'(mon_e.z));
        checkOutput("flag_c", DATA_W'(c_f), DATA_W'(mon_e.c));
        checkOutput("latency", DATA_W'(cyc), DATA_W'(mon_e.due));
        checkOutput("busy_at_done", DATA_W'(busy), '0);
      end
    end
  end

  initial begin
    int snap, k, nb;
    logic [3:0] ro;
    logic [2:0] rw;
    logic [DATA_W-1:0] ra, rb;
    logic rd;
    rst = 1'b1; start = 1'b0; op = '0; width = '0; a = '0; b = '0;
    c_in = 1'b0; v_in = 1'b0; d_in = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", DATA_W'(busy), '0);
    checkOutput("reset_done", DATA_W'(done), '0);
    checkOutput("reset_result", result, '0);
    checkOutput("reset_flags", DATA_W'({n_f, v_f, z_f, c_f}), '0);
    rst = 1'b0;
    @(negedge clk);

    // 8-bit signed overflow
    applyStimulus(4'd0, 3'd0, 128'h7F, 128'h01, 1'b0, 1'b0, 1'b0);
    waitDone("adc8");
    @(negedge clk);

    // 128-bit carry out, with a start pulse while busy that must be ignored
    applyStimulus(4'd0, 3'd4, {DATA_W{1'b1}}, 128'h1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    op = 4'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone("adc128");
    repeat (8) @(negedge clk);

    // 16-bit ROR with junk above bit 15
    applyStimulus(4'd8, 3'd1, {112'hDEAD_BEEF_0000_1234_5678_9ABC_DEF0, 16'h0001},
                  rand_wide(), 1'b1, 1'b0, 1'b0);
    waitDone("ror16");
    @(negedge clk);

    // 32-bit CMP equal, then a back-to-back start in the done cycle
    ra = {96'h0, 32'h12345678};
    applyStimulus(4'd11, 3'd2, ra, ra, 1'b0, 1'b0, 1'b0);
    waitDone("cmp32");
    applyStimulus(4'd4, 3'd2, rand_wide(), rand_wide(), 1'b1, 1'b1, 1'b0);
    waitDone("b2b");
    @(negedge clk);

    // Decimal-mode ADC (binary when BCD support is not built in)
    applyStimulus(4'd0, 3'd0, 128'h19, 128'h01, 1'b0, 1'b0, 1'b1);
    waitDone("adc_bcd");
    @(negedge clk);

    // Reset in the middle of a 64-bit op aborts it
    applyStimulus(4'd1, 3'd3, rand_wide(), rand_wide(), 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("abort_busy", DATA_W'(busy), '0);
    checkOutput("abort_result", result, '0);
    checkOutput("abort_flags", DATA_W'({n_f, v_f, z_f, c_f}), '0);
    sb.delete();
    snap = done_seen;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("abort_no_done", DATA_W'(done_seen - snap), '0);
    applyStimulus(4'd9, 3'd3, rand_wide(), rand_wide(), 1'b0, 1'b1, 1'b0);
    waitDone("after_abort");

    // Randomized operations, sometimes back-to-back
    for (int i = 0; i < 60; i++) begin
      ro = 4'($urandom);
      rw = 3'($urandom);
      rd = 1'($urandom);
      ra = rand_wide();
      rb = rand_wide();
`ifdef CPU_WIDE_ALU_BCD_EN
      if (rd && ro <= 4'd1) begin
        ra = rand_bcd();
        rb = rand_bcd();
      end
`endif
      applyStimulus(ro, rw, ra, rb, 1'($urandom), 1'($urandom), rd);
      waitDone("random");
      nb = $urandom_range(0, 2);
      for (int j = 0; j < nb; j++) @(negedge clk);
    end

    k = 0;
    while (sb.size() != 0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    checkOutput("scoreboard_drained", DATA_W'(sb.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cpu_wide_alu.md
# cpu_wide_alu

Multi-cycle, width-selectable ALU for the enhanced 6502-compatible CPU core. It executes 6502 arithmetic, logic, shift and compare operations on operands of 8 to DATA_W bits. Operands are processed one SLICE_W-bit slice per clock, with carry chained between slices. It sits between the decode stage and the 128-bit register banks, and returns a result plus N/V/Z/C for the processor status register.

## Interface
- DATA_W, 128: maximum operand width; power of two, 8..128.
- SLICE_W, 32: bits processed per cycle; power of two, 8..DATA_W.
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_start  in  1  request; sampled only in IDLE.
- i_op  in  4  0 ADC, 1 SBC, 2 AND, 3 ORA, 4 EOR, 5 ASL, 6 LSR, 7 ROL, 8 ROR, 9 INC, 10 DEC, 11 CMP, 12 BIT, 13-15 PASS.
- i_width  in  3  data width code: 0=8, 1=16, 2=32, 3=64, 4-7=128.
- i_a, i_b  in  DATA_W  operands (i_a is the accumulator/target).
- i_c_in, i_v_in, i_d  in  1 each  current C, V, D status bits.
- o_busy  out  1  operation in progress.
- o_done  out  1  one-cycle completion pulse.
- o_result  out  DATA_W  result, zero-extended above W.
- o_n, o_v, o_z, o_c  out  1 each  resulting flags.

## Operation
- Effective width W = min(8 << i_width code (4-7 treated as 4), DATA_W). Number of slices N = max(1, W / SLICE_W).
- States: IDLE, RUN, FIN.
  - IDLE: when i_start=1, latch all inputs and set o_busy=1, then go to RUN with slice index 0.
  - RUN: compute slice k from the latched operands and the chained carry; k increments each cycle; after slice N-1 go to FIN.
  - FIN: register the flags and o_result, set o_done=1 and o_busy=0, then return to IDLE.
- Slices are processed low to high. Right shifts read the neighbouring bit directly from the latched operand, so no reverse order is needed.
- Results, over bits [W-1:0]:
  - ADC: A+B+C.
  - SBC: A+~B+C.
  - AND/ORA/EOR: bitwise.
  - ASL: shift left, LSB 0. LSR: shift right, MSB 0.
  - ROL: C enters the LSB. ROR: C enters bit W-1.
  - INC: A+1. DEC: A-1.
  - CMP, BIT and PASS: result = A.
- N = result[W-1] and Z = (result[W-1:0]==0), except where noted below.
- C:
  - ADC: carry out of bit W-1.
  - SBC/CMP: no borrow (A-B computed as A+~B+1 for CMP).
  - ASL/ROL: A[W-1]. LSR/ROR: A[0].
  - All other ops: i_c_in.
- V:
  - ADC/SBC: signed overflow at bit W-1.
  - BIT: B[W-2].
  - All other ops: i_v_in.
- CMP flags come from A-B. BIT sets N=B[W-1] and Z=((A&B)[W-1:0]==0).
- i_start while o_busy=1 is ignored. Inputs may change freely after the start cycle.

## Timing
- Reset: state IDLE, o_busy=0, o_done=0, o_result=0, all flags 0.
- Reset during RUN or FIN aborts the operation: no o_done pulse, outputs return to reset values.
- Latency: start sampled at edge t; o_done is high during the cycle after edge t+N+1, i.e. N+1 cycles.
  - 8-bit op at SLICE_W=32: done after 2 cycles.
  - 128-bit op at SLICE_W=32: done after 5 cycles.
- o_result and flags hold their values until the next FIN.
- Back-to-back: i_start asserted in the o_done cycle is accepted, because the state is already IDLE.

## Configuration
- CPU_WIDE_ALU_BCD_EN defined:
  - ADC/SBC with latched D=1 operate on packed BCD over W/4 digits.
  - ADC: a digit result >9 is adjusted by +6 and carries.
  - SBC: a digit borrow is adjusted by -6.
  - C is the decimal carry/no-borrow; V uses the binary computation; N/Z come from the BCD result.
  - Slice carry chains the decimal carry.
- Not defined: i_d is ignored; ADC/SBC are always binary.

## Test plan
- 8-bit ADC A=0x7F, B=0x01, C=0 -> result 0x80, N=1, V=1, Z=0, C=0; o_done 2 cycles after start (SLICE_W=32).
- 128-bit ADC A=all-ones, B=1, C=0 -> result 0, Z=1, C=1, V=0; latency 5; i_start asserted at cycle 2 is ignored.
- 16-bit ROR A=0x0001, C=1 -> result 0x8000, C=1, N=1; bits [127:16] of o_result are 0 even with A upper bits set.
- 32-bit CMP A=B=0x12345678 -> result 0x12345678, Z=1, C=1, N=0; a back-to-back start during o_done is accepted.
- 8-bit ADC A=0x19, B=0x01, D=1 -> 0x20, C=0 with CPU_WIDE_ALU_BCD_EN; 0x1A without it.
- Reset asserted mid 64-bit op -> o_busy=0 immediately, no o_done, o_result=0; next start completes normally.
